matmul_sequencer: RTL and testbench

- Control FSM for the ROM-fed matrix-multiply datapath (ROM A/B, lane multipliers, adder tree, accumulator).
- Sequences C = A x B for N x N matrices.
- Each cycle it issues ROM addresses for one LANES-wide beat of a dot product and tracks beats through the ROM and adder-tree latency.
- Drives accumulator clear/enable, presents each finished C element with a valid/ready handshake, and owns the run cycle counter shown on the HEX display.

---
 rtl/matmul_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Control FSM for the ROM-fed matrix-multiply datapath: issues one LANES-wide beat per
// cycle, tracks beats through the ROM and adder-tree latency, and hands out finished C elements.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | issuing beats, one per enabled cycle
// DRAIN | all beats issued, waiting for tag pipe to empty and last result to be taken
// DONE  | run complete, done high, counters and cycle_count held
module matmul_sequencer #(
    parameter int N        = 64,
    parameter int LANES    = 8,
    parameter int ROM_LAT  = 1,
    parameter int TREE_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      result_ready,
    output logic [2*$clog2(N)-1:0]    rom_a_addr,
    output logic [2*$clog2(N)-1:0]    rom_b_addr,
    output logic                      pipe_en,
    output logic                      acc_clear,
    output logic                      acc_en,
    output logic                      result_valid,
    output logic [$clog2(N)-1:0]      result_row,
    output logic [$clog2(N)-1:0]      result_col,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          cycle_count
);

    localparam int IDX_W = $clog2(N);
    localparam int LAT   = ROM_LAT + TREE_LAT;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(N - LANES);
    localparam logic [IDX_W-1:0] K_STEP   = IDX_W'(LANES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] cnt_i;
    logic [IDX_W-1:0] cnt_j;
    logic [IDX_W-1:0] cnt_k;

    logic [LAT-1:0]   tag_valid;
    logic [LAT-1:0]   tag_first;
    logic [LAT-1:0]   tag_last;
    logic [IDX_W-1:0] tag_i [LAT];
    logic [IDX_W-1:0] tag_j [LAT];

    logic issue;
    logic run_start;
    logic last_beat;
    logic tags_empty;
    logic accept;

    assign last_beat  = (cnt_i == IDX_LAST) && (cnt_j == IDX_LAST) && (cnt_k == K_LAST);
    assign tags_empty = ~|tag_valid;
    assign accept     = result_valid && result_ready;

    // Counters are stable outside RUN, so the addresses hold their last value there.
    assign rom_a_addr = {cnt_i, cnt_k};
    assign rom_b_addr = {cnt_j, cnt_k};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        pipe_en    = 1'b0;
        issue      = 1'b0;
        acc_en     = 1'b0;
        acc_clear  = 1'b0;
        run_start  = 1'b0;

        busy      = (state == RUN) || (state == DRAIN);
        done      = (state == DONE);
        pipe_en   = busy && !(result_valid && !result_ready);
        issue     = (state == RUN) && pipe_en;
        acc_en    = pipe_en && tag_valid[LAT-1];
        acc_clear = acc_en && tag_first[LAT-1];
        run_start = ((state == IDLE) || (state == DONE)) && start;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (issue && last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Once the tag pipe is empty the pending result is the final element.
                if (tags_empty && (accept || !result_valid)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Issue counters: k inner, j middle, i outer; frozen on the last beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_i <= '0;
            cnt_j <= '0;
            cnt_k <= '0;
        end else if (run_start) begin
            cnt_i <= '0;
            cnt_j <= '0;
            cnt_k <= '0;
        end else if (issue && !last_beat) begin
            if (cnt_k == K_LAST) begin
                cnt_k <= '0;
                if (cnt_j == IDX_LAST) begin
                    cnt_j <= '0;
                    cnt_i <= cnt_i + 1'b1;
                end else begin
                    cnt_j <= cnt_j + 1'b1;
                end
            end else begin
                cnt_k <= cnt_k + K_STEP;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid <= '0;
            tag_first <= '0;
            tag_last  <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_i[s] <= '0;
                tag_j[s] <= '0;
            end
        end else if (pipe_en) begin
            tag_valid[0] <= issue;
            tag_first[0] <= (cnt_k == '0);
            tag_last[0]  <= (cnt_k == K_LAST);
            tag_i[0]     <= cnt_i;
            tag_j[0]     <= cnt_j;
            for (int s = 1; s < LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_first[s] <= tag_first[s-1];
                tag_last[s]  <= tag_last[s-1];
                tag_i[s]     <= tag_i[s-1];
                tag_j[s]     <= tag_j[s-1];
            end
        end
    end

    // A new element may complete in the same cycle the previous one is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_valid <= 1'b0;
            result_row   <= '0;
            result_col   <= '0;
        end else if (acc_en && tag_last[LAT-1]) begin
            result_valid <= 1'b1;
            result_row   <= tag_i[LAT-1];
            result_col   <= tag_j[LAT-1];
        end else if (accept) begin
            result_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (run_start) begin
            cycle_count <= '0;
        end else if (busy && (cycle_count != CNT_MAX)) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: N=4, LANES=2, LAT=2, with a datapath model feeding a
// result scoreboard; a second instance with a 5-bit cycle counter checks saturation.
module tb_matmul_sequencer;

    localparam int N        = 4;
    localparam int LANES    = 2;
    localparam int ROM_LAT  = 1;
    localparam int TREE_LAT = 1;
    localparam int LAT      = ROM_LAT + TREE_LAT;
    localparam int KB       = N / LANES;
    localparam int BEATS    = N * N * N / LANES;
    localparam int ELEMS    = N * N;
    localparam int SAT_MAX  = 31;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       result_ready = 1'b1;

    logic [3:0]  rom_a_addr, rom_b_addr;
    logic        pipe_en, acc_clear, acc_en, result_valid, busy, done;
    logic [1:0]  result_row, result_col;
    logic [15:0] cycle_count;

    logic [3:0]  rom_a_addr_s, rom_b_addr_s;
    logic        pipe_en_s, acc_clear_s, acc_en_s, result_valid_s, busy_s, done_s;
    logic [1:0]  result_row_s, result_col_s;
    logic [4:0]  cycle_count_s;

    matmul_sequencer #(.N(N), .LANES(LANES), .ROM_LAT(ROM_LAT), .TREE_LAT(TREE_LAT), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .result_ready(result_ready),
        .rom_a_addr(rom_a_addr), .rom_b_addr(rom_b_addr), .pipe_en(pipe_en),
        .acc_clear(acc_clear), .acc_en(acc_en), .result_valid(result_valid),
        .result_row(result_row), .result_col(result_col), .busy(busy), .done(done),
        .cycle_count(cycle_count)
    );

    matmul_sequencer #(.N(N), .LANES(LANES), .ROM_LAT(ROM_LAT), .TREE_LAT(TREE_LAT), .CNT_W(5)) dut_sat (
        .clock(clock), .reset(reset), .start(start), .result_ready(result_ready),
        .rom_a_addr(rom_a_addr_s), .rom_b_addr(rom_b_addr_s), .pipe_en(pipe_en_s),
        .acc_clear(acc_clear_s), .acc_en(acc_en_s), .result_valid(result_valid_s),
        .result_row(result_row_s), .result_col(result_col_s), .busy(busy_s), .done(done_s),
        .cycle_count(cycle_count_s)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int mat_a [N][N];
    int mat_b [N][N];

    typedef struct { int row; int col; int val; } exp_t;
    exp_t sb [$];

    // Datapath model: ROM output regs, one tree stage, accumulator; all gated by pipe_en.
    int ra_q [LANES];
    int rb_q [LANES];
    int tree_q = 0;
    int acc = 0;

    function automatic int dot();
        int s = 0;
        for (int l = 0; l < LANES; l++) s += ra_q[l] * rb_q[l];
        return s;
    endfunction

    always @(posedge clock) begin
        if (pipe_en === 1'b1) begin
            for (int l = 0; l < LANES; l++) begin
                ra_q[l] <= mat_a[int'(rom_a_addr) / N][(int'(rom_a_addr) + l) % N];
                rb_q[l] <= mat_b[(int'(rom_b_addr) + l) % N][int'(rom_b_addr) / N];
            end
            tree_q <= dot();
        end
        if (acc_en === 1'b1) acc <= (acc_clear === 1'b1) ? tree_q : acc + tree_q;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_mats(input int kind);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mat_a[r][c] = (kind == 0) ? ((r == c) ? 1 : 0) : (r + 2 * c + 1);
                mat_b[r][c] = r * N + c + 1;
            end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_addr"}, rom_a_addr, 0);
        chk({tag, "_b_addr"}, rom_b_addr, 0);
        chk({tag, "_pipe_en"}, pipe_en, 0);
        chk({tag, "_acc_en"}, acc_en, 0);
        chk({tag, "_acc_clear"}, acc_clear, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_row"}, result_row, 0);
        chk({tag, "_col"}, result_col, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_count"}, cycle_count, 0);
        chk({tag, "_sat_valid"}, result_valid_s, 0);
        chk({tag, "_sat_busy"}, busy_s, 0);
        chk({tag, "_sat_count"}, cycle_count_s, 0);
    endtask

    // Called mid-cycle while the DUT is in IDLE or DONE; start goes high in that cycle.
    task automatic run(input int s1, input int s2, input int stall_lo, input int stall_hi,
                       input int rst_c, input int exp_done);
        int p = 0;
        bit rv = 0;
        int accepts = 0;
        int beat, ab, exp_a, exp_b, cs;
        bit pe, ae, ac, al;
        bit aborted = 0;
        exp_t e;

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                e.row = r; e.col = c; e.val = 0;
                for (int k = 0; k < N; k++) e.val += mat_a[r][k] * mat_b[k][c];
                sb.push_back(e);
            end
        start = 1'b1;

        for (int c = 0; c < 300 && accepts < ELEMS; c++) begin
            @(negedge clock);
            start        = (c == s1 || c == s2);
            result_ready = !(c >= stall_lo && c <= stall_hi);
            reset        = (c == rst_c);
            #1;
            pe    = !(rv && !result_ready);
            beat  = (p < BEATS) ? p : BEATS - 1;
            exp_a = (beat / (N * KB)) * N + (beat % KB) * LANES;
            exp_b = ((beat / KB) % N) * N + (beat % KB) * LANES;
            ae    = pe && p >= LAT && p < BEATS + LAT;
            ab    = p - LAT;
            ac    = ae && (ab % KB == 0);
            al    = ae && (ab % KB == KB - 1);
            cs    = (c > SAT_MAX) ? SAT_MAX : c;

            chk("a_addr", rom_a_addr, exp_a);
            chk("b_addr", rom_b_addr, exp_b);
            chk("pipe_en", pipe_en, pe);
            chk("acc_en", acc_en, ae);
            chk("acc_clear", acc_clear, ac);
            chk("result_valid", result_valid, rv);
            chk("busy", busy, 1);
            chk("done", done, 0);
            chk("cycle_count", cycle_count, c);
            chk("sat_a_addr", rom_a_addr_s, exp_a);
            chk("sat_pipe_en", pipe_en_s, pe);
            chk("sat_acc_en", acc_en_s, ae);
            chk("sat_valid", result_valid_s, rv);
            chk("sat_count", cycle_count_s, cs);

            if (rv && result_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("result_row", result_row, e.row);
                chk("result_col", result_col, e.col);
                chk("result_value", acc, e.val);
                chk("sat_row", result_row_s, e.row);
                chk("sat_col", result_col_s, e.col);
                accepts++;
            end

            rv = al ? 1'b1 : ((rv && result_ready) ? 1'b0 : rv);
            if (pe) p++;
            if (c == rst_c) begin
                aborted = 1;
                break;
            end
        end

        if (aborted) begin
            @(negedge clock);
            reset = 1'b0;
            start = 1'b0;
            result_ready = 1'b1;
            #1;
            chk_zero("after_reset");
            for (int c = 0; c < 5; c++) begin
                @(negedge clock);
                #1;
                chk("idle_valid", result_valid, 0);
                chk("idle_busy", busy, 0);
            end
            sb.delete();
        end else begin
            @(negedge clock);
            start = 1'b0;
            result_ready = 1'b1;
            #1;
            chk("accepts", accepts, ELEMS);
            chk("sb_empty", sb.size(), 0);
            chk("done_end", done, 1);
            chk("busy_end", busy, 0);
            chk("valid_end", result_valid, 0);
            chk("pipe_en_end", pipe_en, 0);
            chk("a_addr_end", rom_a_addr, (N - 1) * N + N - LANES);
            chk("count_end", cycle_count, exp_done);
            chk("sat_done_end", done_s, 1);
            chk("sat_count_end", cycle_count_s, (exp_done > SAT_MAX) ? SAT_MAX : exp_done);
        end
    endtask

    initial begin
        set_mats(0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_zero("reset");

        // Plain run, then start pulses in RUN/DRAIN ignored; that run also starts from DONE.
        run(-1, -1, -1, -2, -1, 35);
        run(5, 20, -1, -2, -1, 35);

        set_mats(1);
        run(-1, -1, 4, 9, -1, 41);

        set_mats(0);
        run(-1, -1, -1, -2, 12, 0);
        run(-1, -1, -1, -2, -1, 35);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
